fp_minmax_cmp_pipe: RTL and testbench
=====================================

// Module: fp_minmax_cmp_pipe
// PURPOSE
//  Parametrised, pipelined FP min/max/compare unit; next generation of the single-precision magnitude unit.
//  Generic exponent/mantissa widths, configurable pipeline depth, valid/ready flow control.
//  Adds FEQ/FLT/FLE compare modes to FMIN/FMAX. Sits between FP issue and writeback/round path.
//  RISC-V F/D NaN and exception semantics.
// PARAMETERS
//  EXP_W   8   exponent width (5 = half, 8 = single, 11 = double)
//  MAN_W   23  stored mantissa width (10 / 23 / 52)
//  STAGES  2   pipeline register stages, legal 1..4; FLEN = 1+EXP_W+MAN_W (localparam)
// PORTS
//  clk_i         in   1     clock, all state on rising edge
//  rst_i         in   1     synchronous reset, active-high
//  clk_en_i      in   1     global enable; low = whole pipe frozen
//  valid_i       in   1     operands/op valid
//  ready_o       out  1     unit accepts input this cycle
//  operand_A_i   in   FLEN  operand A
//  operand_B_i   in   FLEN  operand B
//  operation_i   in   3     000 FMIN, 001 FMAX, 010 FEQ, 011 FLT, 100 FLE, others reserved
//  valid_o       out  1     result valid
//  ready_i       in   1     downstream accepts result
//  result_o      out  FLEN  min/max value, or compare result zero-extended (0/1)
//  invalid_op_o  out  1     NV flag for this result
// BEHAVIOUR
//  Reset (rst_i=1 at edge): all stage valid bits 0, result_o=0, invalid_op_o=0, valid_o=0.
//  ready_o=0 while rst_i=1 or clk_en_i=0.
//  Classification (comb, stage 0):
//    NaN = exp all-ones and man!=0; sNaN = NaN with man MSB 0; qNaN = man MSB 1.
//    Canonical NaN = {0, all-ones exp, 1, zeros}; single = 32'h7FC00000.
//  FMIN/FMAX:
//    One NaN: return the other operand. Both NaN: canonical NaN.
//    Any sNaN input: invalid_op_o=1.
//    -0 < +0; compare by sign, then magnitude (exp,man) unsigned, reversed for negatives.
//    Infinities ordered normally; no overflow/underflow generated.
//  FEQ: result 1 iff equal; +0 == -0. Either NaN gives 0; invalid only for sNaN.
//  FLT/FLE: either NaN gives 0 and invalid=1 (qNaN too).
//  Reserved op: result 0, invalid=1.
//  Pipeline:
//    STAGES register slots, each {valid, result, invalid}. Latency = STAGES cycles, no stall.
//    Slot k advances when clk_en_i=1 and (slot k+1 empty or advancing). Last slot advances when ready_i=1.
//    ready_o = clk_en_i & !rst_i & (slot0 empty | slot0 advancing).
//    Input captured when valid_i & ready_o; throughput 1/cycle.
//    valid_o = last-slot valid. result_o/invalid_op_o stable while valid_o & !ready_i.
//    No bubbles inserted, no result dropped or duplicated, strict in-order.
//    clk_en_i=0 holds all slots and outputs unchanged; ready_i ignored that cycle (no handshake).
//    Reset mid-stream discards all in-flight results; first capture allowed the cycle after rst_i drops.
//  Computation placement: all comb logic before slot 0; later slots are pure retiming.
// TESTING
//  FMAX A=40F224DD(7.567) B=40BD70A4(5.92) -> 40F224DD, inv 0, valid_o exactly STAGES cycles after accept.
//  FMIN A=7FC00000(qNaN) B=40BD70A4 -> 40BD70A4, inv 0. FMIN A=7F800001(sNaN) -> 40BD70A4, inv 1.
//  FMIN sNaN,sNaN -> 7FC00000, inv 1. FMIN 80000000,00000000 -> 80000000. FMAX 40BD70A4,FF800000 -> 40BD70A4.
//  FLT 3F99999A,40BD70A4 -> 1, inv 0. FLE qNaN,1.0 -> 0, inv 1.
//    FEQ 00000000,80000000 -> 1. FEQ qNaN,qNaN -> 0, inv 0.
//  Backpressure: stream 6 back-to-back ops, ready_i low 3 cycles mid-stream and clk_en_i low 2 cycles
//    -> all 6 results in order, outputs held stable, ready_o low when full.
//  Reset mid-stream with 2 in flight -> valid_o=0 next cycle, no stale output; half-precision build
//    (EXP_W=5, MAN_W=10) FMAX 3C00,4000 -> 4000, canonical NaN 7E00.

Source files
------------

// File: rtl/fp_minmax_cmp_pipe.sv
// Pipelined FP min/max/compare unit with RISC-V NaN and NV-flag semantics.
// All arithmetic sits ahead of slot 0; later slots only retime the result.
module fp_minmax_cmp_pipe #(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int STAGES = 2,
    localparam int FLEN  = 1 + EXP_W + MAN_W
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clk_en_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [FLEN-1:0] operand_A_i,
    input  logic [FLEN-1:0] operand_B_i,
    input  logic [2:0]      operation_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [FLEN-1:0] result_o,
    output logic            invalid_op_o
);

    localparam logic [2:0] OP_FMIN = 3'b000;
    localparam logic [2:0] OP_FMAX = 3'b001;
    localparam logic [2:0] OP_FEQ  = 3'b010;
    localparam logic [2:0] OP_FLT  = 3'b011;
    localparam logic [2:0] OP_FLE  = 3'b100;

    localparam logic [FLEN-1:0] CANON_NAN =
        {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic [FLEN-2:0]  a_mag, b_mag;
    logic a_sign, b_sign;
    logic a_nan, b_nan, a_snan, b_snan;
    logic any_nan, any_snan, both_zero;
    logic ord_lt, bits_eq, is_min;

    logic [FLEN-1:0] res_d;
    logic            inv_d;

    assign a_sign = operand_A_i[FLEN-1];
    assign b_sign = operand_B_i[FLEN-1];
    assign a_exp  = operand_A_i[FLEN-2 -: EXP_W];
    assign b_exp  = operand_B_i[FLEN-2 -: EXP_W];
    assign a_man  = operand_A_i[MAN_W-1:0];
    assign b_man  = operand_B_i[MAN_W-1:0];
    assign a_mag  = operand_A_i[FLEN-2:0];
    assign b_mag  = operand_B_i[FLEN-2:0];

    assign a_nan  = (&a_exp) & (|a_man);
    assign b_nan  = (&b_exp) & (|b_man);
    assign a_snan = a_nan & ~a_man[MAN_W-1];
    assign b_snan = b_nan & ~b_man[MAN_W-1];

    assign any_nan   = a_nan | b_nan;
    assign any_snan  = a_snan | b_snan;
    assign both_zero = ~(|a_mag) & ~(|b_mag);
    assign bits_eq   = operand_A_i == operand_B_i;

    // Total order with -0 below +0; negatives compare by reversed magnitude.
    assign ord_lt = (a_sign != b_sign) ? a_sign :
                    (a_sign ? (a_mag > b_mag) : (a_mag < b_mag));

    assign is_min = operation_i == OP_FMIN;

    always_comb begin
        res_d = '0;
        inv_d = 1'b0;
        case (operation_i)
            OP_FMIN, OP_FMAX: begin
                inv_d = any_snan;
                if (a_nan & b_nan)
                    res_d = CANON_NAN;
                else if (a_nan)
                    res_d = operand_B_i;
                else if (b_nan)
                    res_d = operand_A_i;
                else if (is_min == ord_lt)
                    res_d = operand_A_i;
                else
                    res_d = operand_B_i;
            end
            OP_FEQ: begin
                inv_d    = any_snan;
                res_d[0] = ~any_nan & (bits_eq | both_zero);
            end
            OP_FLT: begin
                inv_d    = any_nan;
                res_d[0] = ~any_nan & ord_lt & ~both_zero;
            end
            OP_FLE: begin
                inv_d    = any_nan;
                res_d[0] = ~any_nan & (ord_lt | bits_eq | both_zero);
            end
            default: begin
                inv_d = 1'b1;
            end
        endcase
    end

    logic [STAGES-1:0]           vld;
    logic [STAGES-1:0]           inv;
    logic [STAGES-1:0][FLEN-1:0] res;
    logic [STAGES-1:0]           free;
    logic                        fire;

    // A slot can load when it or any slot downstream of it has a hole,
    // or when the output is being drained this cycle.
    for (genvar k = 0; k < STAGES; k++) begin : g_free
        assign free[k] = ready_i | ~(&vld[STAGES-1:k]);
    end

    assign ready_o = clk_en_i & ~rst_i & free[0];
    assign fire    = valid_i & ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld <= '0;
            inv <= '0;
            res <= '0;
        end else if (clk_en_i) begin
            if (free[0]) begin
                vld[0] <= fire;
                res[0] <= res_d;
                inv[0] <= inv_d;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (free[k]) begin
                    vld[k] <= vld[k-1];
                    res[k] <= res[k-1];
                    inv[k] <= inv[k-1];
                end
            end
        end
    end

    assign valid_o      = vld[STAGES-1];
    assign result_o     = res[STAGES-1];
    assign invalid_op_o = inv[STAGES-1];

endmodule

// File: tb/tb_fp_minmax_cmp_pipe.sv
// Scoreboard bench: randomized single-precision ops against an integer-key
// reference model, plus directed flow-control, reset and half-precision cases.
module tb_fp_minmax_cmp_pipe;

    localparam int STG = 2;

    logic        clk = 1'b0;
    logic        rst_i, clk_en_i, valid_i, ready_i;
    logic        ready_o, valid_o, invalid_op_o;
    logic [31:0] operand_A_i, operand_B_i, result_o;
    logic [2:0]  operation_i;

    logic        h_valid, h_ready, h_valid_o, h_inv;
    logic [15:0] h_a, h_b, h_res;
    logic [2:0]  h_op;

    int checks = 0;
    int errors = 0;
    bit rand_mode = 1'b0;

    logic [32:0] q[$];

    always #5 clk = ~clk;

    fp_minmax_cmp_pipe #(.EXP_W(8), .MAN_W(23), .STAGES(STG)) dut (
        .clk_i(clk), .rst_i(rst_i), .clk_en_i(clk_en_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .operand_A_i(operand_A_i), .operand_B_i(operand_B_i),
        .operation_i(operation_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o),
        .invalid_op_o(invalid_op_o)
    );

    fp_minmax_cmp_pipe #(.EXP_W(5), .MAN_W(10), .STAGES(2)) dut_h (
        .clk_i(clk), .rst_i(rst_i), .clk_en_i(1'b1),
        .valid_i(h_valid), .ready_o(h_ready),
        .operand_A_i(h_a), .operand_B_i(h_b),
        .operation_i(h_op), .valid_o(h_valid_o),
        .ready_i(1'b1), .result_o(h_res),
        .invalid_op_o(h_inv)
    );

    // Reference: map each non-NaN value to a signed integer that orders
    // like the real number (both zeros map to 0); returns {invalid, result}.
    function automatic logic [32:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [2:0]  op);
        bit an, bn, as, bs;
        longint ka, kb;
        logic [31:0] r;
        logic inv;
        an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        as = an && !a[22];
        bs = bn && !b[22];
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        r = 32'h0;
        inv = 1'b0;
        case (op)
            3'd0, 3'd1: begin
                inv = as || bs;
                if (an && bn)      r = 32'h7FC00000;
                else if (an)       r = b;
                else if (bn)       r = a;
                else if (ka == kb) r = ((op == 3'd0) == a[31]) ? a : b;
                else               r = ((op == 3'd0) == (ka < kb)) ? a : b;
            end
            3'd2: begin
                inv = as || bs;
                r[0] = !(an || bn) && (ka == kb);
            end
            3'd3: begin
                inv = an || bn;
                r[0] = !(an || bn) && (ka < kb);
            end
            3'd4: begin
                inv = an || bn;
                r[0] = !(an || bn) && (ka <= kb);
            end
            default: inv = 1'b1;
        endcase
        return {inv, r};
    endfunction

    function automatic logic [31:0] rand_val();
        case ($urandom_range(0, 11))
            0: return 32'h00000000;
            1: return 32'h80000000;
            2: return 32'h7F800000;
            3: return 32'hFF800000;
            4: return 32'h7FC00000;
            5: return {1'($urandom_range(0, 1)), 8'hFF, 1'b0,
                       22'($urandom_range(1, 4194303))};
            6: return 32'h3F800000;
            7: return 32'hBF800000;
            default: return $urandom;
        endcase
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
        int n;
        @(negedge clk);
        operand_A_i = a;
        operand_B_i = b;
        operation_i = op;
        valid_i     = 1'b1;
        n = 0;
        while (!ready_o && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout ready_o=%b required 1", ready_o);
            valid_i = 1'b0;
        end else begin
            @(posedge clk);
            q.push_back(model(a, b, op));
            #1 valid_i = 1'b0;
        end
    endtask

    task automatic issue_h(input logic [15:0] a, input logic [15:0] b,
                           input logic [2:0] op, input logic [15:0] er,
                           input logic ei);
        int n;
        @(negedge clk);
        h_a = a;
        h_b = b;
        h_op = op;
        h_valid = 1'b1;
        @(negedge clk);
        h_valid = 1'b0;
        n = 0;
        while (!h_valid_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!h_valid_o || h_res !== er || h_inv !== ei) begin
            errors++;
            $display("FAIL half op%0d %h,%h got v=%b %h inv %b required %h inv %b",
                     op, a, b, h_valid_o, h_res, h_inv, er, ei);
        end
    endtask

    // Monitor: ready_o against occupancy, hold stability, result scoreboard.
    bit          hold_prev = 1'b0;
    logic [31:0] prev_res;
    logic        prev_inv;
    always @(negedge clk) begin
        logic exp_rdy;
        logic [32:0] e;
        exp_rdy = clk_en_i && !rst_i && (q.size() < STG || ready_i);
        checks++;
        if (ready_o !== exp_rdy) begin
            errors++;
            $display("FAIL ready_o got %b required %b (occ %0d)",
                     ready_o, exp_rdy, q.size());
        end
        if (hold_prev) begin
            checks++;
            if (valid_o !== 1'b1 || result_o !== prev_res || invalid_op_o !== prev_inv) begin
                errors++;
                $display("FAIL hold got v=%b %h inv %b required v=1 %h inv %b",
                         valid_o, result_o, invalid_op_o, prev_res, prev_inv);
            end
        end
        if (valid_o && ready_i && clk_en_i && !rst_i) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got %h required none", result_o);
            end else begin
                e = q.pop_front();
                if (result_o !== e[31:0] || invalid_op_o !== e[32]) begin
                    errors++;
                    $display("FAIL result got %h inv %b required %h inv %b",
                             result_o, invalid_op_o, e[31:0], e[32]);
                end
            end
        end
        hold_prev = valid_o && !(ready_i && clk_en_i) && !rst_i;
        prev_res  = result_o;
        prev_inv  = invalid_op_o;
    end

    always @(posedge clk) begin
        #1;
        if (rand_mode) begin
            ready_i  = ($urandom_range(0, 3) != 0);
            clk_en_i = ($urandom_range(0, 6) != 0);
        end
    end

    initial begin
        logic [31:0] da[10] = '{32'h40F224DD, 32'h7FC00000, 32'h7F800001,
                                32'h7F800001, 32'h80000000, 32'h40BD70A4,
                                32'h3F99999A, 32'h7FC00000, 32'h00000000,
                                32'h7FC00000};
        logic [31:0] db[10] = '{32'h40BD70A4, 32'h40BD70A4, 32'h40BD70A4,
                                32'h7F800001, 32'h00000000, 32'hFF800000,
                                32'h40BD70A4, 32'h3F800000, 32'h80000000,
                                32'h7FC00000};
        logic [2:0]  dop[10] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1,
                                 3'd3, 3'd4, 3'd2, 3'd2};
        int n;

        rst_i = 1'b1;
        clk_en_i = 1'b1;
        ready_i = 1'b1;
        valid_i = 1'b0;
        operand_A_i = '0;
        operand_B_i = '0;
        operation_i = '0;
        h_valid = 1'b0;
        h_a = '0;
        h_b = '0;
        h_op = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || result_o !== 32'h0 || invalid_op_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b %h inv %b required 0 0 0",
                     valid_o, result_o, invalid_op_o);
        end
        @(posedge clk);
        #1 rst_i = 1'b0;

        // Directed cases; the first one also measures latency.
        issue(da[0], db[0], dop[0]);
        for (int k = 1; k <= STG; k++) begin
            @(negedge clk);
            checks++;
            if (valid_o !== (k == STG)) begin
                errors++;
                $display("FAIL latency cycle %0d valid_o got %b required %b",
                         k, valid_o, k == STG);
            end
        end
        for (int i = 1; i < 10; i++) issue(da[i], db[i], dop[i]);
        issue(32'h3F800000, 32'h3F800000, 3'd6);

        // Back-to-back burst with downstream stall and a global freeze.
        fork
            for (int i = 0; i < 6; i++)
                issue(32'h40000000 + i, 32'h40000003, 3'(i % 5));
            begin
                repeat (2) @(posedge clk);
                #1 ready_i = 1'b0;
                repeat (3) @(posedge clk);
                #1 ready_i = 1'b1;
                clk_en_i = 1'b0;
                repeat (2) @(posedge clk);
                #1 clk_en_i = 1'b1;
            end
        join

        // Randomized traffic with random stalls.
        rand_mode = 1'b1;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a, b;
            int r;
            a = rand_val();
            case ($urandom_range(0, 5))
                0: b = a;
                1: b = a ^ 32'h80000000;
                default: b = rand_val();
            endcase
            r = $urandom_range(0, 11);
            issue(a, b, (r < 10) ? 3'(r % 5) : 3'(r - 5));
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        @(posedge clk);
        rand_mode = 1'b0;
        #1 ready_i = 1'b1;
        clk_en_i = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", q.size());
        end

        // Reset with two results stuck in the pipe.
        #1 ready_i = 1'b0;
        issue(32'h3F800000, 32'h40000000, 3'd1);
        issue(32'h3F800000, 32'h40000000, 3'd0);
        rst_i = 1'b1;
        @(posedge clk);
        #1 rst_i = 1'b0;
        q.delete();
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0 || result_o !== 32'h0 || invalid_op_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset got v=%b %h inv %b required 0 0 0",
                     valid_o, result_o, invalid_op_o);
        end
        @(posedge clk);
        #1 ready_i = 1'b1;
        issue(32'hC0000000, 32'h3F800000, 3'd0);
        repeat (STG + 2) @(negedge clk);

        // Half-precision build.
        issue_h(16'h3C00, 16'h4000, 3'd1, 16'h4000, 1'b0);
        issue_h(16'h7C01, 16'h7C01, 3'd0, 16'h7E00, 1'b1);
        issue_h(16'h7C01, 16'h3C00, 3'd1, 16'h3C00, 1'b1);
        issue_h(16'h0000, 16'h8000, 3'd2, 16'h0001, 1'b0);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL final_queue pending %0d required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
